// File: rtl/miner_cmd_ctrl_if.sv
// rtl/miner_cmd_ctrl_if.sv - Host byte link and core-array signal bundle for miner_cmd_ctrl
interface miner_cmd_ctrl_if #(
    parameter int NUM_CORES = 2
);
    logic                     byte_valid;
    logic [7:0]               rx_byte;
    logic [7:0]               tx_byte;
    logic                     core_start;
    logic [255:0]             core_prev_H;
    logic [95:0]              core_input_M;
    logic [255:0]             core_prev_blk;
    logic [32*NUM_CORES-1:0]  core_nonce_base;
    logic [NUM_CORES-1:0]     core_done;
    logic [NUM_CORES-1:0]     core_found;
    logic [32*NUM_CORES-1:0]  core_nonce;
    logic [256*NUM_CORES-1:0] core_hash;

    // Host SPI slave and core array side
    modport master (
        output byte_valid, rx_byte, core_done, core_found, core_nonce, core_hash,
        input  tx_byte, core_start, core_prev_H, core_input_M, core_prev_blk, core_nonce_base
    );

    // Command controller side
    modport slave (
        input  byte_valid, rx_byte, core_done, core_found, core_nonce, core_hash,
        output tx_byte, core_start, core_prev_H, core_input_M, core_prev_blk, core_nonce_base
    );
endinterface

// File: rtl/miner_cmd_ctrl.sv
// rtl/miner_cmd_ctrl.sv - Host command decoder, pending job slot and core result arbiter (optional MINER_CHKSUM_EN job checksum)
module miner_cmd_ctrl #(
    parameter int NUM_CORES  = 2,
    parameter int CORE_IDX_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
    input  logic            clk,
    input  logic            reset,
    miner_cmd_ctrl_if.slave bus
);
    localparam logic [7:0] ST_WAITING    = 8'hA0;
    localparam logic [7:0] ST_WORKING    = 8'hA1;
    localparam logic [7:0] ST_DONE       = 8'hA5;
    localparam logic [7:0] ST_DONE_FOUND = 8'hA6;
    localparam logic [7:0] ST_ERROR      = 8'hA8;
    localparam logic [7:0] CMD_JOB_START  = 8'hA2;
    localparam logic [7:0] CMD_GET_RESULT = 8'hA4;
    localparam logic [7:0] CMD_ABORT      = 8'hA7;
`ifdef MINER_CHKSUM_EN
    localparam int JOB_BYTES = 77;
`else
    localparam int JOB_BYTES = 76;
`endif
    localparam int         JOB_W     = 608;
    localparam logic [6:0] LAST_BYTE = 7'(JOB_BYTES - 1);
    localparam logic [6:0] TX_LAST   = 7'd36;
    localparam int         NB_SHIFT  = 32 - $clog2(NUM_CORES);

    typedef enum logic [1:0] {L_CMD, L_RX_JOB, L_TX_RES} link_t;
    typedef enum logic {M_IDLE, M_RUN} mine_t;

    link_t l_state, l_next;
    mine_t m_state, m_next;

    logic [6:0]            byte_cnt;
    logic [JOB_W-1:0]      stage;
    logic [JOB_W-1:0]      pend_job;
    logic                  pend_valid;
    logic [7:0]            status_q, status_d;
    logic [7:0]            tx_byte_q;
    logic [287:0]          tx_shift;
    logic                  core_start_q;
    logic [255:0]          act_prev_H, act_prev_blk;
    logic [95:0]           act_input_M;
    logic [NUM_CORES-1:0]  done_mask;
    logic                  res_valid;
    logic [CORE_IDX_W-1:0] res_idx;
    logic [31:0]           res_nonce;
    logic [255:0]          res_hash;

    logic                  cmd_byte, is_job_start, is_get_result, is_abort;
    logic                  rx_last, commit, job_err, tx_end, chk_ok;
    logic [JOB_W-1:0]      commit_job, start_job;
    logic                  start_go, run_finish, capture;
    logic [NUM_CORES-1:0]  found_vec;
    logic [CORE_IDX_W-1:0] found_idx;
    logic [31:0]           found_nonce;
    logic [255:0]          found_hash;
    logic [295:0]          payload;

    assign cmd_byte      = (l_state == L_CMD) && bus.byte_valid;
    assign is_job_start  = cmd_byte && (bus.rx_byte == CMD_JOB_START);
    assign is_get_result = cmd_byte && (bus.rx_byte == CMD_GET_RESULT);
    assign is_abort      = cmd_byte && (bus.rx_byte == CMD_ABORT);
    assign rx_last       = (byte_cnt == LAST_BYTE);
    assign commit        = (l_state == L_RX_JOB) && bus.byte_valid && rx_last && chk_ok;
    assign job_err       = (l_state == L_RX_JOB) && bus.byte_valid && rx_last && !chk_ok;
    assign tx_end        = (l_state == L_TX_RES) && bus.byte_valid && (byte_cnt == TX_LAST);

`ifdef MINER_CHKSUM_EN
    logic [7:0] chk_acc;
    assign chk_ok     = (bus.rx_byte == chk_acc);
    assign commit_job = stage;

    // Running XOR of the 76 job bytes, restarted by every JOB_START
    always_ff @(posedge clk) begin
        if (reset || is_job_start)
            chk_acc <= '0;
        else if ((l_state == L_RX_JOB) && bus.byte_valid && !rx_last)
            chk_acc <= chk_acc ^ bus.rx_byte;
    end
`else
    assign chk_ok     = 1'b1;
    assign commit_job = {stage[JOB_W-9:0], bus.rx_byte};
`endif

    // Link FSM state register
    always_ff @(posedge clk) begin
        if (reset) l_state <= L_CMD;
        else       l_state <= l_next;
    end

    // Link FSM: command decode, job reception and result transmission phases
    always_comb begin
        l_next = l_state;
        case (l_state)
            L_CMD: begin
                if (is_job_start)       l_next = L_RX_JOB;
                else if (is_get_result) l_next = L_TX_RES;
            end
            L_RX_JOB: if (bus.byte_valid && rx_last) l_next = L_CMD;
            L_TX_RES: if (tx_end) l_next = L_CMD;
            default:  l_next = L_CMD;
        endcase
    end

    // Byte position within the current job or result transfer
    always_ff @(posedge clk) begin
        if (reset || is_job_start || is_get_result)
            byte_cnt <= '0;
        else if ((l_state != L_CMD) && bus.byte_valid)
            byte_cnt <= byte_cnt + 7'd1;
    end

    // Staging buffer fills MSB-first so byte 0 ends up at the top
    always_ff @(posedge clk) begin
        if (reset)
            stage <= '0;
        else if ((l_state == L_RX_JOB) && bus.byte_valid && (byte_cnt < 7'd76))
            stage <= {stage[JOB_W-9:0], bus.rx_byte};
    end

    // Lowest-indexed core reporting a find this cycle
    always_comb begin
        found_vec   = bus.core_done & bus.core_found;
        found_idx   = '0;
        found_nonce = '0;
        found_hash  = '0;
        for (int i = NUM_CORES - 1; i >= 0; i--) begin
            if (found_vec[i]) begin
                found_idx   = CORE_IDX_W'(i);
                found_nonce = bus.core_nonce[32*i +: 32];
                found_hash  = bus.core_hash[256*i +: 256];
            end
        end
        capture = (m_state == M_RUN) && !is_abort && !res_valid && (|found_vec);
    end

    // Mining FSM state register
    always_ff @(posedge clk) begin
        if (reset) m_state <= M_IDLE;
        else       m_state <= m_next;
    end

    // Mining FSM: launch a job when idle, wait for every core to report done
    always_comb begin
        m_next     = m_state;
        start_go   = 1'b0;
        run_finish = 1'b0;
        start_job  = pend_valid ? pend_job : commit_job;
        if (is_abort) begin
            m_next = M_IDLE;
        end else begin
            case (m_state)
                M_IDLE: begin
                    if (pend_valid || commit) begin
                        start_go = 1'b1;
                        m_next   = M_RUN;
                    end
                end
                M_RUN: begin
                    if (&(done_mask | bus.core_done)) begin
                        run_finish = 1'b1;
                        m_next     = M_IDLE;
                    end
                end
                default: m_next = M_IDLE;
            endcase
        end
    end

    // Single pending slot; a commit into an occupied slot is dropped
    always_ff @(posedge clk) begin
        if (reset || is_abort) begin
            pend_valid <= 1'b0;
            pend_job   <= '0;
        end else begin
            if (start_go && pend_valid)
                pend_valid <= 1'b0;
            if (commit && !pend_valid && !start_go) begin
                pend_valid <= 1'b1;
                pend_job   <= commit_job;
            end
        end
    end

    // Active job registers and the start strobe they accompany
    always_ff @(posedge clk) begin
        if (reset) begin
            act_prev_H   <= '0;
            act_input_M  <= '0;
            act_prev_blk <= '0;
            core_start_q <= 1'b0;
        end else begin
            core_start_q <= start_go;
            if (start_go) begin
                act_prev_H   <= start_job[607:352];
                act_input_M  <= start_job[351:256];
                act_prev_blk <= start_job[255:0];
            end
        end
    end

    // Per-run done tracking and first-find result capture
    always_ff @(posedge clk) begin
        if (reset) begin
            done_mask <= '0;
            res_valid <= 1'b0;
            res_idx   <= '0;
            res_nonce <= '0;
            res_hash  <= '0;
        end else if (start_go) begin
            done_mask <= '0;
            res_valid <= 1'b0;
        end else begin
            if (m_state == M_RUN)
                done_mask <= done_mask | bus.core_done;
            if (tx_end)
                res_valid <= 1'b0;
            if (capture) begin
                res_valid <= 1'b1;
                res_idx   <= found_idx;
                res_nonce <= found_nonce;
                res_hash  <= found_hash;
            end
        end
    end

    // Status update; later assignments take precedence
    always_comb begin
        status_d = status_q;
        if (run_finish)
            status_d = (res_valid || capture) ? ST_DONE_FOUND : ST_DONE;
        if (start_go)
            status_d = ST_WORKING;
        if ((commit && pend_valid) || job_err)
            status_d = ST_ERROR;
        if (tx_end)
            status_d = (m_next == M_RUN) ? ST_WORKING : ST_WAITING;
        if (is_abort)
            status_d = ST_WAITING;
    end

    // Status register
    always_ff @(posedge clk) begin
        if (reset) status_q <= ST_WAITING;
        else       status_q <= status_d;
    end

    assign payload = res_valid ? {8'(res_idx), res_hash, res_nonce} : {8'hFF, 288'd0};

    // Response byte: result payload while transmitting, otherwise status once back in CMD
    always_ff @(posedge clk) begin
        if (reset) begin
            tx_byte_q <= ST_WAITING;
            tx_shift  <= '0;
        end else if (is_get_result) begin
            tx_byte_q <= payload[295:288];
            tx_shift  <= payload[287:0];
        end else if ((l_state == L_TX_RES) && bus.byte_valid && !tx_end) begin
            tx_byte_q <= tx_shift[287:280];
            tx_shift  <= {tx_shift[279:0], 8'h00};
        end else if (l_next == L_CMD) begin
            tx_byte_q <= status_d;
        end
    end

    assign bus.tx_byte       = tx_byte_q;
    assign bus.core_start    = core_start_q;
    assign bus.core_prev_H   = act_prev_H;
    assign bus.core_input_M  = act_input_M;
    assign bus.core_prev_blk = act_prev_blk;

    for (genvar g = 0; g < NUM_CORES; g++) begin : g_nonce_base
        assign bus.core_nonce_base[32*g +: 32] = 32'(g) << NB_SHIFT;
    end
endmodule

// File: doc/miner_cmd_ctrl.md
# miner_cmd_ctrl

Command-layer controller between the SPI byte slave and a parametrised array of SHA-256d pipeline cores. It decodes host commands, assembles 76-byte jobs and keeps one job pending behind the running one. It fans each job out to NUM_CORES cores, each with a disjoint nonce sub-range, and arbitrates their results. It then serialises the winning hash and nonce back to the host.

## Interface
- NUM_CORES, 2, number of attached cores; power of two, 1..8
- CORE_IDX_W, $clog2(NUM_CORES) (min 1), core index width
- clk  in  1  system clock
- reset  in  1  synchronous, active-high
- byte_valid  in  1  one-cycle pulse: rx_byte holds a new SPI byte
- rx_byte  in  8  received byte
- tx_byte  out  8  byte the SPI slave sends on the next exchange
- core_start  out  1  one-cycle pulse to all cores
- core_prev_H  out  256  first-stage hash of the active job
- core_input_M  out  96  message tail of the active job
- core_prev_blk  out  256  previous-block hash of the active job
- core_nonce_base  out  32*NUM_CORES  start nonce per core; slice i = i << (32-log2 NUM_CORES), 0 for NUM_CORES=1
- core_done  in  NUM_CORES  one-cycle done pulse per core
- core_found  in  NUM_CORES  qualifies core_done
- core_nonce  in  32*NUM_CORES  winning nonce per core, valid with core_done
- core_hash  in  256*NUM_CORES  winning hash per core, valid with core_done

## Operation
- Status codes: WAITING 0xA0, WORKING 0xA1, DONE 0xA5, DONE_FOUND 0xA6, ERROR 0xA8.
- Commands are accepted only in CMD state: 0xA2 JOB_START goes to RX_JOB; 0xA4 GET_RESULT goes to TX_RES; 0xA7 ABORT drops the active and pending jobs and sets status WAITING. Any other byte is ignored.
- Link FSM has three states: CMD, RX_JOB and TX_RES.
- RX_JOB collects 76 bytes MSB-first: bytes 0-31 prev_H, 32-43 input_M, 44-75 prev_blk. Bytes go into a staging buffer. The last byte commits the buffer as the pending job and returns the FSM to CMD.
- Mining FSM has two states: M_IDLE and M_RUN.
  - M_IDLE with a pending job: copy it to the active registers, pulse core_start, enter M_RUN, set status WORKING.
  - In M_RUN, each core_done sets a done_mask bit. The first core_found (lowest index on simultaneous pulses) captures its index, nonce and hash. Later finds are ignored.
  - When all done_mask bits are set, go to M_IDLE with status DONE_FOUND if a result was captured, otherwise DONE. A pending job then starts on the following cycle.
- Pending overflow: if a job commits while one is already pending, the new job is discarded and status becomes ERROR. The active run is unaffected.
- TX_RES sends 37 bytes: core index (zero-extended), hash MSB-first (32), nonce MSB-first (4). If no result was captured, the index byte is 0xFF and the rest are 0x00. After byte 37 the FSM returns to CMD, the captured result clears, and status becomes WAITING unless mining is in M_RUN (then WORKING).
- core_done pulses arriving in M_IDLE are ignored.

## Timing
- Reset values:
  - tx_byte = 0xA0.
  - core_start = 0.
  - core_prev_H, core_input_M and core_prev_blk are all zero.
  - Both FSMs are idle, the pending-job register is empty, and the result registers are cleared.
- tx_byte is registered and updates the cycle after the byte_valid that caused it.
- In TX_RES, tx_byte shows payload byte k after byte_valid number k. The first payload byte is loaded on the GET_RESULT byte itself.
- core_start asserts 1 cycle after the final job byte when mining is idle. The core_* job outputs are stable from core_start until the next core_start.
- Status changes made while in RX_JOB or TX_RES are latched. tx_byte reflects them only after the return to CMD; payload bytes always take priority.
- byte_valid and core_done in the same cycle: both are processed.
- ABORT in the same cycle as the final core_done: ABORT wins and status is WAITING.
- Reset mid-transfer or mid-run returns everything to reset values within 1 cycle.

## Configuration
- MINER_CHKSUM_EN defined: a job is 77 bytes, and byte 76 must equal the XOR of bytes 0-75. On mismatch the job is not committed, status becomes ERROR, and the FSM returns to CMD.
- MINER_CHKSUM_EN undefined: a job is 76 bytes and there is no checksum logic.

## Test plan
- Reset, then exchange one byte: tx_byte = 0xA0, core_start = 0.
- NUM_CORES=4, send 0xA2 plus a 76-byte ramp (0x00..0x4B):
  - core_start pulses once; core_prev_H = 0x00..1F, core_input_M = 0x20..2B.
  - core_nonce_base = {0xC0000000, 0x80000000, 0x40000000, 0}.
  - Status is 0xA1.
- Cores 1 and 3 pulse done+found in the same cycle (nonces 0x11, 0x33), then cores 0 and 2 pulse done:
  - Status 0xA6.
  - GET_RESULT returns 0x01, then core 1's hash, then 00 00 00 11.
  - Status returns to 0xA0.
- All cores finish without found: status 0xA5; GET_RESULT returns 0xFF followed by 36×0x00.
- Job A runs, job B is sent (pending), then job C is sent: status 0xA8. After A completes, core_start pulses with B's data.
- With MINER_CHKSUM_EN, send a job with a wrong checksum byte: no core_start, status 0xA8. With a correct checksum, core_start pulses.
